// File: rtl/iomem_arbiter.sv
// Two-master, one-slave arbiter for the picosoc iomem bus.
// Round-robin grant held until slave completion, with a bus-timeout watchdog.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic        sys_clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_pulse,
    output logic [31:0] timeout_addr
);

    localparam logic [0:0]  IDLE = 1'b0;
    localparam logic [0:0]  BUSY = 1'b1;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [0:0]  state;
    logic        last;
    logic [15:0] count;

    logic        g_valid;
    logic [3:0]  g_wstrb;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        complete;
    logic        timed_out;
    logic [31:0] resp_data;

    assign g_valid = grant ? m1_valid : m0_valid;
    assign g_wstrb = grant ? m1_wstrb : m0_wstrb;
    assign g_addr  = grant ? m1_addr  : m0_addr;
    assign g_wdata = grant ? m1_wdata : m0_wdata;

    assign busy = (state == BUSY);

    // A slave answer in the final watchdog cycle still counts as a normal completion.
    assign complete  = busy && g_valid && s_ready;
    assign timed_out = busy && g_valid && !s_ready && (count == TIMEOUT_LAST);

    assign s_valid = busy && g_valid && !timed_out;
    assign s_wstrb = busy ? g_wstrb : 4'b0000;
    assign s_addr  = busy ? g_addr  : 32'h0;
    assign s_wdata = busy ? g_wdata : 32'h0;

    assign resp_data = timed_out ? TIMEOUT_RDATA : s_rdata;
    assign m0_ready  = (complete || timed_out) && !grant;
    assign m1_ready  = (complete || timed_out) && grant;
    assign m0_rdata  = m0_ready ? resp_data : 32'h0;
    assign m1_rdata  = m1_ready ? resp_data : 32'h0;

    assign timeout_pulse = timed_out;

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last         <= 1'b1;
            count        <= 16'h0;
            timeout_addr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant <= (m0_valid && m1_valid) ? ~last : m1_valid;
                        count <= 16'h0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // An aborted request leaves the round-robin history untouched.
                    if (!g_valid) begin
                        state <= IDLE;
                    end else if (complete || timed_out) begin
                        last  <= grant;
                        state <= IDLE;
                        if (timed_out) begin
                            timeout_addr <= g_addr;
                        end
                    end else if (count != 16'hFFFF) begin
                        count <= count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: a scoreboard of expected completions
// is filled as requests are issued and drained by a negedge monitor.
module tb_iomem_arbiter;

    logic        sys_clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        grant, busy, timeout_pulse;
    logic [31:0] timeout_addr;

    typedef struct packed {
        logic        mst;
        logic [31:0] rdata;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    iomem_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
        .sys_clk(sys_clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse), .timeout_addr(timeout_addr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit mst, input logic [3:0] wstrb,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (mst) begin
            m1_valid = 1'b1; m1_wstrb = wstrb; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_valid = 1'b1; m0_wstrb = wstrb; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pushExp(input bit mst, input logic [31:0] rdata, input bit to);
        exp_t e;
        e.mst = mst; e.rdata = rdata; e.to = to;
        exp_q.push_back(e);
    endtask

    // Slave model: answers `lat` cycles after it first sees s_valid.
    task automatic slaveServe(input int lat, input logic [31:0] data);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (!s_valid && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        checkOutput("svalid_wait", {31'h0, s_valid}, 32'h1);
        for (int i = 0; i < lat; i++) step();
        s_ready = 1'b1;
        s_rdata = data;
        step();
        s_ready = 1'b0;
        s_rdata = 32'h0;
    endtask

    task automatic pulseReset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    // Scoreboard drain plus per-cycle invariants on read-data gating.
    always @(negedge sys_clk) begin
        exp_t e;
        if (mon_on) begin
            if (m0_ready || m1_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ready_master", {30'h0, m1_ready, m0_ready}, e.mst ? 32'h2 : 32'h1);
                    checkOutput("ready_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
                    checkOutput("ready_timeout", {31'h0, timeout_pulse}, {31'h0, e.to});
                end
            end
            if (!m0_ready) checkOutput("m0_rdata_gated", m0_rdata, 32'h0);
            if (!m1_ready) checkOutput("m1_rdata_gated", m1_rdata, 32'h0);
            checkOutput("pulse_without_ready",
                        {31'h0, timeout_pulse & ~(m0_ready | m1_ready)}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetn = 1'b0;
        m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_ready = 1'b0; s_rdata = 32'h0;
        step();
        step();
        @(negedge sys_clk);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_grant", {31'h0, grant}, 32'h0);
        checkOutput("rst_svalid", {31'h0, s_valid}, 32'h0);
        checkOutput("rst_taddr", timeout_addr, 32'h0);
        mon_on = 1'b1;
        step();
        resetn = 1'b1;
        step();

        $display("[TB] single write from master 0");
        applyStimulus(1'b0, 4'b0011, 32'h0300_0000, 32'h0000_00A5);
        pushExp(1'b0, 32'h0, 1'b0);
        @(negedge sys_clk);
        checkOutput("t1_no_early_svalid", {31'h0, s_valid}, 32'h0);
        step();
        @(negedge sys_clk);
        checkOutput("t1_svalid", {31'h0, s_valid}, 32'h1);
        checkOutput("t1_saddr", s_addr, 32'h0300_0000);
        checkOutput("t1_swdata", s_wdata, 32'h0000_00A5);
        checkOutput("t1_swstrb", {28'h0, s_wstrb}, 32'h3);
        checkOutput("t1_grant", {31'h0, grant}, 32'h0);
        step();
        s_ready = 1'b1;
        @(negedge sys_clk);
        checkOutput("t1_m0_ready", {31'h0, m0_ready}, 32'h1);
        checkOutput("t1_m1_ready", {31'h0, m1_ready}, 32'h0);
        step();
        s_ready = 1'b0;
        m0_valid = 1'b0;
        @(negedge sys_clk);
        checkOutput("t1_ready_pulse", {31'h0, m0_ready}, 32'h0);
        checkOutput("t1_idle", {31'h0, busy}, 32'h0);

        $display("[TB] fairness with both masters requesting");
        step();
        pulseReset();
        applyStimulus(1'b0, 4'h0, 32'h0300_0010, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'h0300_0014, 32'h0);
        for (int k = 0; k < 4; k++) pushExp(k[0], 32'h100 + k, 1'b0);
        for (int k = 0; k < 4; k++) slaveServe(1, 32'h100 + k);
        m0_valid = 1'b0;

        $display("[TB] master 1 read");
        applyStimulus(1'b1, 4'h0, 32'h0300_0000, 32'h0);
        s_rdata = 32'h1234_5678;
        pushExp(1'b1, 32'h1234_5678, 1'b0);
        slaveServe(1, 32'h1234_5678);
        m1_valid = 1'b0;

        $display("[TB] timeout on unmapped address");
        applyStimulus(1'b0, 4'h0, 32'h0400_0010, 32'h0);
        pushExp(1'b0, 32'hDEAD_BEEF, 1'b1);
        @(negedge sys_clk);
        checkOutput("t4_idle_first", {31'h0, busy}, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            step();
            @(negedge sys_clk);
            checkOutput("t4_busy", {31'h0, busy}, 32'h1);
            checkOutput("t4_svalid", {31'h0, s_valid}, (i < 8) ? 32'h1 : 32'h0);
            checkOutput("t4_pulse", {31'h0, timeout_pulse}, (i == 8) ? 32'h1 : 32'h0);
            checkOutput("t4_m0_ready", {31'h0, m0_ready}, (i == 8) ? 32'h1 : 32'h0);
        end
        step();
        m0_valid = 1'b0;
        @(negedge sys_clk);
        checkOutput("t4_taddr", timeout_addr, 32'h0400_0010);
        checkOutput("t4_idle_after", {31'h0, busy}, 32'h0);

        $display("[TB] slave answers on the timeout cycle");
        step();
        applyStimulus(1'b0, 4'h0, 32'h0500_0020, 32'h0);
        pushExp(1'b0, 32'h0BAD_F00D, 1'b0);
        @(negedge sys_clk);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 8) begin
                s_ready = 1'b1;
                s_rdata = 32'h0BAD_F00D;
            end
            @(negedge sys_clk);
            checkOutput("t5_svalid", {31'h0, s_valid}, 32'h1);
            checkOutput("t5_pulse", {31'h0, timeout_pulse}, 32'h0);
        end
        checkOutput("t5_m0_ready", {31'h0, m0_ready}, 32'h1);
        step();
        s_ready = 1'b0;
        s_rdata = 32'h0;
        m0_valid = 1'b0;
        @(negedge sys_clk);
        checkOutput("t5_taddr_kept", timeout_addr, 32'h0400_0010);

        $display("[TB] reset during busy");
        step();
        applyStimulus(1'b0, 4'hF, 32'h0600_0000, 32'h1111_2222);
        @(negedge sys_clk);
        repeat (2) begin
            step();
            @(negedge sys_clk);
            checkOutput("t6_busy", {31'h0, busy}, 32'h1);
        end
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        m0_valid = 1'b0;
        @(negedge sys_clk);
        checkOutput("t6_rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("t6_rst_svalid", {31'h0, s_valid}, 32'h0);
        checkOutput("t6_rst_taddr", timeout_addr, 32'h0);

        $display("[TB] master abort then arbitration");
        step();
        applyStimulus(1'b0, 4'h0, 32'h0700_0000, 32'h0);
        @(negedge sys_clk);
        repeat (2) begin
            step();
            @(negedge sys_clk);
        end
        step();
        m0_valid = 1'b0;
        @(negedge sys_clk);
        checkOutput("t6_abort_svalid", {31'h0, s_valid}, 32'h0);
        checkOutput("t6_abort_ready", {31'h0, m0_ready}, 32'h0);
        step();
        applyStimulus(1'b0, 4'h0, 32'h0300_0020, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'h0300_0024, 32'h0);
        pushExp(1'b0, 32'hCAFE_0001, 1'b0);
        pushExp(1'b1, 32'hCAFE_0002, 1'b0);
        @(negedge sys_clk);
        checkOutput("t6_abort_idle", {31'h0, busy}, 32'h0);
        slaveServe(1, 32'hCAFE_0001);
        m0_valid = 1'b0;
        slaveServe(1, 32'hCAFE_0002);
        m1_valid = 1'b0;
        step();
        @(negedge sys_clk);

        checkOutput("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Two-master, one-slave arbiter for the picosoc iomem bus.
- Shares the single peripheral iomem port (GPIO window 0x03xxxxxx and future peripherals) between the CPU (master 0) and a second bus master (master 1, e.g. debug/DMA loader).
- Round-robin grant, held until slave completion.
- Bus-timeout watchdog guarantees a hung or unmapped slave never stalls either master.

Parameters:
- TIMEOUT_CYCLES, 256: cycles in BUSY without s_ready before forced completion; legal range 2..65535.
- TIMEOUT_RDATA, 32'hDEADBEEF: read data returned on a timed-out access.

Ports:
- sys_clk  in  1  system clock
- resetn  in  1  synchronous reset, active-low
- m0_valid  in  1  master 0 request; held high until m0_ready
- m0_wstrb  in  4  master 0 byte write strobes; 0 = read
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_ready  out  1  master 0 completion, 1-cycle pulse
- m0_rdata  out  32  master 0 read data, valid when m0_ready
- m1_valid, m1_wstrb, m1_addr, m1_wdata, m1_ready, m1_rdata: same as master 0, for master 1
- s_valid  out  1  request to slave
- s_wstrb  out  4  forwarded strobes
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  1  index of owning master, valid while busy
- busy  out  1  arbiter in BUSY state
- timeout_pulse  out  1  one-cycle pulse on forced completion
- timeout_addr  out  32  address of most recent timed-out access

Behaviour:
- Reset (resetn=0 at a sys_clk edge):
  - state=IDLE, grant=0, last=1 (master 0 wins the first tie), timeout counter=0, timeout_addr=0.
  - All outputs 0.
  - Reset mid-transaction abandons it with no ready to either master.
- States:
  - IDLE: s_valid=0, m*_ready=0.
    - Only one valid asserted: grant that master.
    - Both valid: grant the master that is not "last".
    - Go to BUSY on the next edge, with counter cleared.
    - Arbitration latency is 1 cycle, so a request is seen by the slave no earlier than the cycle after valid rises.
  - BUSY:
    - s_valid/s_wstrb/s_addr/s_wdata are combinational copies of the granted master's inputs.
    - s_valid = granted valid. The non-granted master's inputs are ignored; its ready stays 0.
  - BUSY with s_ready=1 (and granted valid=1):
    - Granted m_ready=1 combinationally that cycle.
    - Granted m_rdata=s_rdata.
    - Next edge: last=grant, state=IDLE.
  - BUSY with granted valid=0 (master abort): next edge → IDLE. No ready; last is unchanged.
  - BUSY with counter==TIMEOUT_CYCLES-1 and s_ready=0:
    - s_valid forced 0 that cycle.
    - Granted m_ready=1, m_rdata=TIMEOUT_RDATA.
    - timeout_pulse=1.
    - timeout_addr<=granted addr.
    - last=grant, state → IDLE.
  - Otherwise the counter increments by 1 per BUSY cycle. The counter is 16 bits, compares exactly, and never wraps.
- s_ready in the same cycle as a timeout: s_ready wins and it is a normal completion with no timeout_pulse.
- m*_rdata is 0 whenever the corresponding ready is 0.
- s_ready while IDLE is ignored.
- The mandatory IDLE cycle after every completion lets the master drop valid. Back-to-back requests from one master therefore take at least 2 cycles plus slave latency.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.

Test Plan:
1. Reset, then m0 write addr=0x03000000 wdata=0x000000A5 wstrb=4'b0011; slave ready 1 cycle after s_valid → s_valid rises 1 cycle after m0_valid; m0_ready single pulse; grant=0; m1_ready stays 0.
2. m0 and m1 both valid at the same cycle, each re-requesting immediately after ready, for 4 transactions → grant order 0,1,0,1 with no starvation.
3. m1 read addr=0x03000000, s_rdata=0x12345678 with s_ready → m1_rdata=0x12345678 only in the m1_ready cycle, 0 otherwise.
4. TIMEOUT_CYCLES=8, slave never ready, m0 read addr=0x04000010 → m0_ready and timeout_pulse on the 8th BUSY cycle; m0_rdata=0xDEADBEEF; timeout_addr=0x04000010; s_valid=0 that cycle.
5. s_ready asserted exactly on the timeout cycle → normal completion with s_rdata; timeout_pulse=0; timeout_addr unchanged.
6. resetn pulled low during BUSY; also m0 dropping valid mid-BUSY → IDLE next edge, no ready to any master; next request arbitrates normally.
